alu_issue_scheduler: RTL

//  Reservation station plus issue scheduler for the single integer ALU. Holds up to RS_DEPTH

---
 rtl/instruction_pkg.sv | 58 +++++
 rtl/rs_oldest_select.sv | 62 ++++++
 rtl/alu_issue_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/instruction_pkg.sv
// Shared types for the integer-ALU issue path: ALU op encoding, reservation
// station entry layout and the payload handed to the ALU on issue.
package instruction_pkg;

  localparam int unsigned PTAG_WIDTH    = 6;
  localparam int unsigned ROB_IDX_WIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALUFunctions;

  typedef struct packed {
    logic                     valid;
    ALUFunctions              func;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [PTAG_WIDTH-1:0]    dst_tag;
    logic [PTAG_WIDTH-1:0]    src1_tag;
    logic                     src1_rdy;
    logic [PTAG_WIDTH-1:0]    src2_tag;
    logic                     src2_rdy;
    logic                     use_imm;
  } rs_entry_t;

  typedef struct packed {
    ALUFunctions              func;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [PTAG_WIDTH-1:0]    dst_tag;
    logic [PTAG_WIDTH-1:0]    src1_tag;
    logic [PTAG_WIDTH-1:0]    src2_tag;
    logic                     use_imm;
  } alu_issue_t;

  // An entry may be selected once it is valid and both operands are available.
  function automatic logic entry_ready(input rs_entry_t e);
    return e.valid && e.src1_rdy && e.src2_rdy;
  endfunction

  function automatic alu_issue_t to_issue(input rs_entry_t e);
    alu_issue_t p;
    p.func     = e.func;
    p.rob_idx  = e.rob_idx;
    p.dst_tag  = e.dst_tag;
    p.src1_tag = e.src1_tag;
    p.src2_tag = e.src2_tag;
    p.use_imm  = e.use_imm;
    return p;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Age-matrix oldest-first picker for the reservation station.
//  clk, rst_n     clock, async active-low reset (clears the matrix)
//  flush_i        clear the matrix (all entries are being dropped)
//  valid_i        entries currently occupied (registered view)
//  req_i          entries requesting issue
//  alloc_oh_i     entry written this cycle; becomes younger than all survivors
//  free_oh_i      entry released this cycle; its age column is cleared
//  grant_oh_o     one-hot oldest requester (combinational)
//  grant_valid_o  any requester present (combinational)
module rs_oldest_select #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] alloc_oh_i,
  input  logic [N-1:0] free_oh_i,
  output logic [N-1:0] grant_oh_o,
  output logic         grant_valid_o
);

  // age_q[i][j] set means entry j is older than entry i.
  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];

  // Grant the requester that has no older requester.
  always_comb begin
    grant_oh_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_oh_o[i] = req_i[i] && ((age_q[i] & req_i) == '0);
    end
    grant_valid_o = |req_i;
  end

  // Matrix update: drop freed columns, then install the newly allocated row.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i] & ~free_oh_i & ~alloc_oh_i;
      if (alloc_oh_i[i]) begin
        age_d[i] = valid_i & ~free_oh_i & ~alloc_oh_i;
      end
      if (flush_i) begin
        age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station and oldest-ready issue scheduler for the integer ALU.
//  clk, rst_n            clock, async active-low reset
//  flush                 squash every held op; dispatch/wakeup ignored that cycle
//  disp_*                dispatch request and decoded op from rename
//  disp_ready            a free entry exists (from registered occupancy)
//  cdb_valid, cdb_tag    result broadcast used for wakeup and dispatch bypass
//  issue_valid/ready     handshake to the ALU; payload on issue_*
//  rs_count              number of occupied entries
module alu_issue_scheduler
  import instruction_pkg::*;
#(
  parameter int unsigned RS_DEPTH  = 4,
  parameter int unsigned PTAG_W    = PTAG_WIDTH,
  parameter int unsigned ROB_IDX_W = ROB_IDX_WIDTH,
  localparam int unsigned CNT_W    = $clog2(RS_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [3:0]           disp_func,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  input  logic [PTAG_W-1:0]    disp_dst_tag,
  input  logic [PTAG_W-1:0]    disp_src1_tag,
  input  logic                 disp_src1_rdy,
  input  logic [PTAG_W-1:0]    disp_src2_tag,
  input  logic                 disp_src2_rdy,
  input  logic                 disp_use_imm,
  input  logic                 cdb_valid,
  input  logic [PTAG_W-1:0]    cdb_tag,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [3:0]           issue_func,
  output logic [ROB_IDX_W-1:0] issue_rob_idx,
  output logic [PTAG_W-1:0]    issue_dst_tag,
  output logic [PTAG_W-1:0]    issue_src1_tag,
  output logic [PTAG_W-1:0]    issue_src2_tag,
  output logic                 issue_use_imm,
  output logic [CNT_W-1:0]     rs_count
);

  rs_entry_t            entries_q [RS_DEPTH];
  rs_entry_t            entries_d [RS_DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;

  logic [RS_DEPTH-1:0]  valid_vec, req_vec;
  logic [RS_DEPTH-1:0]  free_slot_oh, alloc_oh, free_oh, grant_oh;
  logic                 grant_valid;
  logic                 disp_fire, issue_fire;
  rs_entry_t            new_entry;
  alu_issue_t           issue_pl;

  // Occupancy and readiness views of the registered entries.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      req_vec[i]   = entry_ready(entries_q[i]);
    end
  end

  // Lowest-index free entry.
  always_comb begin
    logic found;
    free_slot_oh = '0;
    found        = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_vec[i] && !found) begin
        free_slot_oh[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign disp_ready  = (count_q != CNT_W'(RS_DEPTH));
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign issue_valid = grant_valid && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign alloc_oh    = disp_fire  ? free_slot_oh : '0;
  assign free_oh     = issue_fire ? grant_oh     : '0;

  rs_oldest_select #(
    .N (RS_DEPTH)
  ) u_select (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .valid_i       (valid_vec),
    .req_i         (req_vec),
    .alloc_oh_i    (alloc_oh),
    .free_oh_i     (free_oh),
    .grant_oh_o    (grant_oh),
    .grant_valid_o (grant_valid)
  );

  // Incoming entry, with same-cycle CDB bypass on both sources.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.func     = ALUFunctions'(disp_func);
    new_entry.rob_idx  = disp_rob_idx;
    new_entry.dst_tag  = disp_dst_tag;
    new_entry.src1_tag = disp_src1_tag;
    new_entry.src2_tag = disp_src2_tag;
    new_entry.use_imm  = disp_use_imm;
    new_entry.src1_rdy = disp_src1_rdy || (cdb_valid && (cdb_tag == disp_src1_tag));
    new_entry.src2_rdy = disp_src2_rdy || disp_use_imm ||
                         (cdb_valid && (cdb_tag == disp_src2_tag));
  end

  // Entry array next state: wakeup, release on issue, allocate, flush.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (cdb_valid && (entries_q[i].src1_tag == cdb_tag)) begin
        entries_d[i].src1_rdy = 1'b1;
      end
      if (cdb_valid && (entries_q[i].src2_tag == cdb_tag)) begin
        entries_d[i].src2_rdy = 1'b1;
      end
      if (free_oh[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc_oh[i]) begin
        entries_d[i] = new_entry;
      end
      if (flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
    end
  end

  // Issue payload from the granted (oldest ready) entry.
  always_comb begin
    issue_pl = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant_oh[i]) begin
        issue_pl = to_issue(entries_q[i]);
      end
    end
  end

  assign issue_func     = issue_pl.func;
  assign issue_rob_idx  = issue_pl.rob_idx;
  assign issue_dst_tag  = issue_pl.dst_tag;
  assign issue_src1_tag = issue_pl.src1_tag;
  assign issue_src2_tag = issue_pl.src2_tag;
  assign issue_use_imm  = issue_pl.use_imm;
  assign rs_count       = count_q;

endmodule
